dense_layer_pe: RTL and testbench
=================================

Name: dense_layer_pe

Overview:
- Parametrised fully-connected layer engine for the fixed-point MLP chain. It is the successor to the fixed 18/36-bit per-layer wrappers.
- Computes y[o] = act(sat((b[o] + sum_i x[i]*W[o*N_IN+i]) >>> FRAC)) over a configurable number of parallel MAC lanes.
- Adds a start/busy/done handshake, output saturation and a selectable ReLU. Instances chain layer to layer: done of one stage drives start of the next.

Parameters:
- DATA_W, 18, signed width of x, W, y.
- ACC_W, 36, signed accumulator width; b is ACC_W wide.
- FRAC, 15, fractional bits of x, W and y. Bias is in Q(2*FRAC) accumulator scale.
- N_IN, 2, number of inputs.
- N_OUT, 20, number of outputs.
- P, 4, parallel MAC lanes, 1..N_OUT.
- RELU, 0, 1 clamps negative outputs to 0 after saturation.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- x  in  DATA_W x [0:N_IN-1]  inputs; latched when start is accepted.
- W  in  DATA_W x [0:N_OUT*N_IN-1]  row-major weights; held stable while busy.
- b  in  ACC_W x [0:N_OUT-1]  biases; held stable while busy.
- y  out  DATA_W x [0:N_OUT-1]  results; registered, held until overwritten.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  level; high while the last results are valid; cleared when the next start is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; y all 0; busy=0; done=0; accumulators, counters and x latch cleared. Reset asserted mid-operation aborts immediately. No partial results survive.
- States:
  - IDLE: start=1 -> latch x, clear done, set busy, g=0, i=0, go to MAC.
  - MAC: each lane l computes o=g*P+l.
    - When i=0: acc[l] <= b[o] + x[0]*W[o*N_IN]. Bias load and the first product happen in the same cycle.
    - Otherwise: acc[l] <= acc[l] + x[i]*W[o*N_IN+i].
    - i increments; after i=N_IN-1 go to WB.
  - WB: for each lane with o<N_OUT, y[o] <= act(sat(acc[l] >>> FRAC)). Lanes with o>=N_OUT write nothing.
    - If g = G-1, with G=ceil(N_OUT/P): go to IDLE, busy=0, done=1.
    - Else g++, i=0, go to MAC.
- Latency: G*(N_IN+1) clocks from the start-accept edge to done rising. With defaults (G=5, N_IN=2) this is 15.
- Arithmetic:
  - Products are full 2*DATA_W signed, sign-extended to ACC_W.
  - Accumulation wraps at ACC_W. The intended range is documented as sized so that wrap does not occur.
  - The shift is arithmetic (floor, no rounding).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - When RELU=1, a negative value becomes 0 after saturation.
- Handshake and timing:
  - start while busy is ignored.
  - start in the same cycle done is high is accepted; done falls on the next edge.
  - y values from the previous run remain visible until each is overwritten in its group's WB cycle.
  - Consumers must use y only while done=1.
- N_IN=1: each group is MAC (1 cycle) + WB. P=N_OUT: a single group.

Decomposition:
- Package dense_pkg:
  - Function sat_shift(acc, FRAC, DATA_W) performing shift plus saturation.
  - Function relu.
  - State enum {IDLE, MAC, WB}.
  - Localparam helper ceil_div.
- Sub-module mac_lane, instantiated P times:
  - Holds one ACC_W accumulator.
  - Inputs: clear_with_bias, en, x, w, b.
  - Output: acc.

Test Plan:
- Reset mid-run:
  - Stimulus: defaults; start; pull reset low at cycle 5; release.
  - Required: y all 0, done=0, busy=0 immediately after reset asserts.
  - Then a fresh start completes normally in 15 cycles.
- Basic dot product:
  - Stimulus: N_IN=2, N_OUT=3, P=2, RELU=0. x={16384, -32768}. Rows {32768,16384}, {32768,32768}, {0,-16384}. b={0, 1073741824, 0}.
  - Required: y={0, 16384, 16384}. done rises exactly 6 cycles after start; busy high for cycles 1-5.
- Saturation:
  - Stimulus: x0=131071, W=131071 (positive case); then W=-131072 (negative case); b=0, N_IN=1.
  - Required: y=131071 for the positive case and -131072 for the negative case.
- ReLU:
  - Stimulus: RELU=1; same stimulus as the basic dot product with row 2 changed to {0,16384}.
  - Required: y2=0 (would be -16384 with RELU=0).
- Partial last group:
  - Stimulus: N_OUT=5, P=2.
  - Required: y[0..4] are correct; no write is attempted beyond index 4; latency is 3*(N_IN+1).
- Handshake:
  - Stimulus: pulse start while busy; then pulse start in the cycle done=1.
  - Required: the first pulse is ignored. The second is accepted: done falls next edge, x is relatched, and the new results appear after the full latency.

Source files
------------

// File: rtl/dense_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dense_pkg
// Description : Shared types and fixed-point helpers for the dense layer engine.
// Revision    : 1.0 - initial release
// ============================================================================
package dense_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Arithmetic (floor) shift followed by clamping to a signed data_w range.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 data_w
    );
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> frac;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (sh > hi)
            return hi;
        else if (sh < lo)
            return lo;
        else
            return sh;
    endfunction

    function automatic logic signed [63:0] relu(
        input logic signed [63:0] v,
        input bit                 en
    );
        return (en && (v < 0)) ? 64'sd0 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_layer_pe_mac_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_lane
// Description : One multiply-accumulate lane; bias load and first product
//               are folded into a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_lane import dense_pkg::*; #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 36
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_with_bias,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [ACC_W-1:0]  b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod     = (2*DATA_W)'(x) * (2*DATA_W)'(w);
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= (clear_with_bias ? b : r_acc) + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/dense_layer_pe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dense_layer_pe
// Description : Fully-connected layer engine, P parallel MAC lanes processing
//               outputs in groups, with saturation and optional ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_layer_pe import dense_pkg::*; #(
    parameter int DATA_W = 18,
    parameter int ACC_W  = 36,
    parameter int FRAC   = 15,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 20,
    parameter int P      = 4,
    parameter int RELU   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] x [0:N_IN-1],
    input  logic signed [DATA_W-1:0] W [0:N_OUT*N_IN-1],
    input  logic signed [ACC_W-1:0]  b [0:N_OUT-1],
    output logic signed [DATA_W-1:0] y [0:N_OUT-1],
    output logic                     busy,
    output logic                     done
);

    localparam int C_G      = ceil_div(N_OUT, P);
    localparam int C_GW     = (C_G > 1)           ? $clog2(C_G)          : 1;
    localparam int C_IW     = (N_IN > 1)          ? $clog2(N_IN)         : 1;
    localparam int C_OW     = (N_OUT > 1)         ? $clog2(N_OUT)        : 1;
    localparam int C_WIDX_W = (N_OUT * N_IN > 1)  ? $clog2(N_OUT * N_IN) : 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [C_GW-1:0]           r_g;
    logic [C_IW-1:0]           r_i;
    logic                      r_busy;
    logic                      r_done;
    logic signed [DATA_W-1:0]  r_x [0:N_IN-1];
    logic signed [DATA_W-1:0]  r_y [0:N_OUT-1];

    logic                      w_lane_en;
    logic                      w_clear;
    logic                      w_last_i;
    logic                      w_last_g;
    logic signed [DATA_W-1:0]  w_xsel;
    logic signed [DATA_W-1:0]  w_res [0:P-1];

    assign w_last_i = (r_i == C_IW'(N_IN - 1));
    assign w_last_g = (r_g == C_GW'(C_G - 1));

    generate
        if (N_IN == 1) begin : g_x_single
            assign w_xsel = r_x[0];
        end else begin : g_x_multi
            assign w_xsel = r_x[r_i];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lane_en   = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = MAC;
                end
            end
            MAC: begin
                w_lane_en = 1'b1;
                w_clear   = (r_i == '0);
                if (w_last_i) begin
                    w_state_nxt = WB;
                end
            end
            WB: begin
                w_state_nxt = w_last_g ? IDLE : MAC;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_g    <= '0;
            r_i    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x    <= x;
                        r_done <= 1'b0;
                        r_busy <= 1'b1;
                        r_g    <= '0;
                        r_i    <= '0;
                    end
                end
                MAC: begin
                    r_i <= w_last_i ? '0 : r_i + 1'b1;
                end
                WB: begin
                    if (w_last_g) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_g <= r_g + 1'b1;
                        r_i <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    generate
        for (genvar l = 0; l < P; l++) begin : g_lane
            logic signed [DATA_W-1:0] w_w;
            logic signed [ACC_W-1:0]  w_b;
            logic signed [ACC_W-1:0]  w_acc;

            // Lanes that fall past the last output in a partial group see zeros.
            always_comb begin
                int o;
                o   = int'(r_g) * P + l;
                w_w = '0;
                w_b = '0;
                if (o < N_OUT) begin
                    w_w = W[C_WIDX_W'(o * N_IN + int'(r_i))];
                    w_b = b[C_OW'(o)];
                end
            end

            mac_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk             (clk),
                .reset           (reset),
                .clear_with_bias (w_clear),
                .en              (w_lane_en),
                .x               (w_xsel),
                .w               (w_w),
                .b               (w_b),
                .acc             (w_acc)
            );

            assign w_res[l] = DATA_W'(relu(sat_shift(64'(w_acc), FRAC, DATA_W), RELU != 0));
        end
    endgenerate

    // Each output has a fixed lane and group, so writeback needs no dynamic index.
    generate
        for (genvar o = 0; o < N_OUT; o++) begin : g_out
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_y[o] <= '0;
                end else if ((r_state == WB) && (r_g == C_GW'(o / P))) begin
                    r_y[o] <= w_res[o % P];
                end
            end
        end
    endgenerate

    assign y    = r_y;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_pe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dense_layer_pe
// Description : Scoreboard bench for dense_layer_pe over several configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_layer_pe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] start_v = '0;
    always #5 clk = ~clk;

    // u0: defaults; u1: basic; u2: saturation; u3: relu; u4: partial group
    logic signed [17:0] x0 [0:1];  logic signed [17:0] w0 [0:39]; logic signed [35:0] b0 [0:19]; logic signed [17:0] y0 [0:19];
    logic signed [17:0] x1 [0:1];  logic signed [17:0] w1 [0:5];  logic signed [35:0] b1 [0:2];  logic signed [17:0] y1 [0:2];
    logic signed [17:0] x2 [0:0];  logic signed [17:0] w2 [0:1];  logic signed [35:0] b2 [0:1];  logic signed [17:0] y2 [0:1];
    logic signed [17:0] x3 [0:1];  logic signed [17:0] w3 [0:5];  logic signed [35:0] b3 [0:2];  logic signed [17:0] y3 [0:2];
    logic signed [17:0] x4 [0:1];  logic signed [17:0] w4 [0:9];  logic signed [35:0] b4 [0:4];  logic signed [17:0] y4 [0:4];
    wire busy0, busy1, busy2, busy3, busy4, done0, done1, done2, done3, done4;
    wire [4:0] busy_v = {busy4, busy3, busy2, busy1, busy0};
    wire [4:0] done_v = {done4, done3, done2, done1, done0};

    dense_layer_pe u0 (.clk(clk), .reset(reset), .start(start_v[0]), .x(x0), .W(w0), .b(b0), .y(y0), .busy(busy0), .done(done0));
    dense_layer_pe #(.N_OUT(3), .P(2)) u1 (.clk(clk), .reset(reset), .start(start_v[1]), .x(x1), .W(w1), .b(b1), .y(y1), .busy(busy1), .done(done1));
    dense_layer_pe #(.N_IN(1), .N_OUT(2), .P(2)) u2 (.clk(clk), .reset(reset), .start(start_v[2]), .x(x2), .W(w2), .b(b2), .y(y2), .busy(busy2), .done(done2));
    dense_layer_pe #(.N_OUT(3), .P(2), .RELU(1)) u3 (.clk(clk), .reset(reset), .start(start_v[3]), .x(x3), .W(w3), .b(b3), .y(y3), .busy(busy3), .done(done3));
    dense_layer_pe #(.N_OUT(5), .P(2)) u4 (.clk(clk), .reset(reset), .start(start_v[4]), .x(x4), .W(w4), .b(b4), .y(y4), .busy(busy4), .done(done4));

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [5][$];

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic sb_check(input int k, input int idx, input int got);
        int e;
        n_checks++;
        if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL sb dut%0d y[%0d]: got %0d, nothing expected", k, idx, got);
        end else begin
            e = exp_q[k].pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL sb dut%0d y[%0d]: got %0d, expected %0d", k, idx, got, e);
            end
        end
    endtask

    // Monitors: outputs are compared whenever a DUT raises done.
    always @(posedge done0) begin #1; for (int i = 0; i < 20; i++) sb_check(0, i, int'(y0[i])); end
    always @(posedge done1) begin #1; for (int i = 0; i < 3;  i++) sb_check(1, i, int'(y1[i])); end
    always @(posedge done2) begin #1; for (int i = 0; i < 2;  i++) sb_check(2, i, int'(y2[i])); end
    always @(posedge done3) begin #1; for (int i = 0; i < 3;  i++) sb_check(3, i, int'(y3[i])); end
    always @(posedge done4) begin #1; for (int i = 0; i < 5;  i++) sb_check(4, i, int'(y4[i])); end

    function automatic int model_y(input longint bias, input longint xa, input longint wa,
                                   input longint xb, input longint wb, input bit relu_en);
        longint v;
        v = (bias + xa * wa + xb * wb) >>> 15;
        if (v > 131071)  v = 131071;
        if (v < -131072) v = -131072;
        if (relu_en && v < 0) v = 0;
        return int'(v);
    endfunction

    task automatic push_u0();
        for (int o = 0; o < 20; o++)
            exp_q[0].push_back(model_y(b0[o], x0[0], w0[2*o], x0[1], w0[2*o+1], 1'b0));
    endtask

    // Pulse start on DUT k, then time done and watch busy, bounded by a cycle budget.
    task automatic run(input int k, input int lat);
        int cyc;
        int busy_low;
        cyc = 0;
        busy_low = 0;
        @(negedge clk); start_v[k] = 1'b1;
        @(negedge clk); start_v[k] = 1'b0;
        chk($sformatf("dut%0d busy after accept", k), busy_v[k], 1);
        chk($sformatf("dut%0d done cleared on accept", k), done_v[k], 0);
        while (!done_v[k] && cyc < lat + 20) begin
            @(negedge clk);
            cyc++;
            if (!done_v[k] && !busy_v[k]) busy_low++;
        end
        chk($sformatf("dut%0d latency", k), cyc, lat);
        chk($sformatf("dut%0d busy low while running", k), busy_low, 0);
        chk($sformatf("dut%0d busy at done", k), busy_v[k], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int nz;
        for (int o = 0; o < 20; o++) begin
            w0[2*o]   = 18'(($signed(o) - 10) * 3000);
            w0[2*o+1] = 18'(7000 * o - 60000);
            b0[o]     = 36'((longint'(o % 4) - 1) * (longint'(1) <<< 28));
        end
        x0[0] = 18'sd32768; x0[1] = 18'sd16384;

        x1[0] = 18'sd16384; x1[1] = -18'sd32768;
        w1[0] = 18'sd32768; w1[1] = 18'sd16384; w1[2] = 18'sd32768; w1[3] = 18'sd32768; w1[4] = 18'sd0; w1[5] = -18'sd16384;
        b1[0] = 36'sd0; b1[1] = 36'sd1073741824; b1[2] = 36'sd0;
        x3 = x1; w3 = w1; b3 = b1; w3[5] = 18'sd16384;

        x2[0] = 18'sd131071; w2[0] = 18'sd131071; w2[1] = -18'sd131072; b2[0] = '0; b2[1] = '0;

        x4[0] = 18'sd32768; x4[1] = 18'sd16384;
        for (int o = 0; o < 5; o++) begin
            w4[2*o]   = 18'(1000 * (o + 1));
            w4[2*o+1] = 18'(-2000 * o);
            b4[o]     = 36'(o * 3276800);
        end

        // Reset state
        #1;
        nz = 0;
        for (int o = 0; o < 20; o++) if (y0[o] != 0) nz++;
        chk("reset y zero", nz, 0);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic dot product: {0, 16384, 16384}
        exp_q[1].push_back(0); exp_q[1].push_back(16384); exp_q[1].push_back(16384);
        run(1, 6);
        // ReLU clamps the -16384 of row 2
        exp_q[3].push_back(0); exp_q[3].push_back(16384); exp_q[3].push_back(0);
        run(3, 6);
        // Saturation, positive and negative
        exp_q[2].push_back(131071); exp_q[2].push_back(-131072);
        run(2, 2);
        // Partial last group: y = 1000 + 100*o
        for (int o = 0; o < 5; o++) exp_q[4].push_back(1000 + 100 * o);
        run(4, 9);

        // Reset mid-run: abort at cycle 5, everything cleared immediately
        @(negedge clk); start_v[0] = 1'b1;
        @(negedge clk); start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        nz = 0;
        for (int o = 0; o < 20; o++) if (y0[o] != 0) nz++;
        chk("midrun reset y zero", nz, 0);
        chk("midrun reset busy", busy0, 0);
        chk("midrun reset done", done0, 0);
        @(negedge clk); reset = 1'b1;
        push_u0();
        run(0, 15);

        // Handshake: a pulse while busy is ignored, x changes after accept are not seen
        x0[0] = 18'sd100000; x0[1] = -18'sd90000;
        push_u0();
        fork
            run(0, 15);
            begin
                repeat (4) @(negedge clk);
                x0[0] = 18'sd1; x0[1] = 18'sd1;
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join
        // Start while done is high: accepted, done falls, new x relatched
        x0[0] = -18'sd32768; x0[1] = 18'sd65536;
        push_u0();
        run(0, 15);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) chk($sformatf("dut%0d scoreboard drained", k), exp_q[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
